// File: rtl/run_seq_pkg.sv
`default_nettype none
// run_seq_pkg: shared state encoding, latched command record and helpers for run_sequencer.  rev 1.0
package run_seq_pkg;

   localparam int SEQ_ADDR_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      RUN    = 3'd3,
      READ   = 3'd4,
      FINISH = 3'd5
   } state_e;

   typedef struct packed {
      logic [SEQ_ADDR_W-1:0] ld_base;
      logic [SEQ_ADDR_W:0]   ld_len;
      logic [SEQ_ADDR_W-1:0] rd_base;
      logic [SEQ_ADDR_W:0]   rd_len;
   } cmd_t;

   function automatic logic len_nonzero(input logic [SEQ_ADDR_W:0] len);
      return len != '0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/run_sequencer_beat_counter.sv
`default_nettype none
// beat_counter: base+index address generator with last-beat flag, shared by the LOAD and READ windows.  rev 1.0
module beat_counter #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

   logic [ADDR_W:0] idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx <= '0;
      end else if (clear) begin
         idx <= '0;
      end else if (advance) begin
         idx <= idx + IDX_ONE;
      end
   end

   // Index is one wider than the address so a full 256-word window can match len.
   assign addr = base + idx[ADDR_W-1:0];
   assign last = (idx + IDX_ONE) == len;

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// run_sequencer: preloads data_mem, starts the core, times its run, then streams a data_mem window back.  rev 1.0
module run_sequencer
   import run_seq_pkg::*;
#(
   parameter int ADDR_W  = SEQ_ADDR_W,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_ld_base,
   input  logic [ADDR_W:0]   cmd_ld_len,
   input  logic [ADDR_W-1:0] cmd_rd_base,
   input  logic [ADDR_W:0]   cmd_rd_len,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   output logic              rs_valid,
   input  logic              rs_ready,
   output logic [DATA_W-1:0] rs_data,
   output logic              rs_last,
   output logic              mem_own,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              dut_start,
   input  logic              dut_done,
   output logic              busy,
   output logic              run_done,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e            state;
   cmd_t              cmd;
   logic              in_read;
   logic              beat_clear;
   logic              beat_fire;
   logic              beat_last;
   logic [ADDR_W-1:0] beat_addr;
   logic [ADDR_W-1:0] beat_base;
   logic [ADDR_W:0]   beat_len;
   logic [CNT_W-1:0]  cnt_next;

   assign in_read    = (state == READ);
   assign beat_clear = !((state == LOAD) || in_read);
   assign beat_base  = in_read ? cmd.rd_base : cmd.ld_base;
   assign beat_len   = in_read ? cmd.rd_len  : cmd.ld_len;
   assign mem_wen    = ld_ready & ld_valid;
   assign beat_fire  = mem_wen | (rs_valid & rs_ready);
   assign cnt_next   = cycle_count + CNT_ONE;

   beat_counter #(.ADDR_W(ADDR_W)) u_beat (
      .clk     (clk),
      .reset   (reset),
      .clear   (beat_clear),
      .advance (beat_fire),
      .base    (beat_base),
      .len     (beat_len),
      .addr    (beat_addr),
      .last    (beat_last)
   );

   // Gated so the data_mem port and result stream read as zero whenever they are not in use.
   assign mem_addr  = mem_own  ? beat_addr : '0;
   assign mem_wdata = mem_wen  ? ld_data   : '0;
   assign rs_data   = rs_valid ? mem_rdata : '0;
   assign rs_last   = rs_valid & beat_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cmd         <= '0;
         cmd_ready   <= 1'b1;
         ld_ready    <= 1'b0;
         rs_valid    <= 1'b0;
         mem_own     <= 1'b0;
         dut_start   <= 1'b0;
         busy        <= 1'b0;
         run_done    <= 1'b0;
         timeout_err <= 1'b0;
         cycle_count <= '0;
      end else begin
         dut_start <= 1'b0;
         run_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd         <= '{ld_base: cmd_ld_base, ld_len: cmd_ld_len,
                                   rd_base: cmd_rd_base, rd_len: cmd_rd_len};
                  cycle_count <= '0;
                  timeout_err <= 1'b0;
                  cmd_ready   <= 1'b0;
                  busy        <= 1'b1;
                  if (len_nonzero(cmd_ld_len)) begin
                     state    <= LOAD;
                     ld_ready <= 1'b1;
                     mem_own  <= 1'b1;
                  end else begin
                     state     <= START;
                     dut_start <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (mem_wen && beat_last) begin
                  state     <= START;
                  ld_ready  <= 1'b0;
                  mem_own   <= 1'b0;
                  dut_start <= 1'b1;
               end
            end
            START: begin
               cycle_count <= '0;
               state       <= RUN;
            end
            RUN: begin
               cycle_count <= cnt_next;
               // done is checked before the timeout so a same-cycle done is not an error
               if (dut_done) begin
                  if (len_nonzero(cmd.rd_len)) begin
                     state    <= READ;
                     mem_own  <= 1'b1;
                     rs_valid <= 1'b1;
                  end else begin
                     state    <= FINISH;
                     run_done <= 1'b1;
                  end
               end else if (cnt_next == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= FINISH;
                  run_done    <= 1'b1;
               end
            end
            READ: begin
               if (rs_valid && rs_ready && beat_last) begin
                  state    <= FINISH;
                  rs_valid <= 1'b0;
                  mem_own  <= 1'b0;
                  run_done <= 1'b1;
               end
            end
            FINISH: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               ld_ready  <= 1'b0;
               rs_valid  <= 1'b0;
               mem_own   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// tb_run_sequencer: scoreboard bench with a core/memory model and a command-level reference.  rev 1.0
module tb_run_sequencer;

   localparam int TMO = 100;

   typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
   typedef struct { logic [7:0] data; logic last; } rs_t;
   typedef struct { logic to; logic [15:0] cyc; } done_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_ld_base = '0;
   logic [8:0] cmd_ld_len = '0;
   logic [7:0] cmd_rd_base = '0;
   logic [8:0] cmd_rd_len = '0;
   logic       ld_valid = 1'b0;
   logic       ld_ready;
   logic [7:0] ld_data = '0;
   logic       rs_valid;
   logic       rs_ready = 1'b0;
   logic [7:0] rs_data;
   logic       rs_last;
   logic       mem_own;
   logic       mem_wen;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       dut_start;
   logic       dut_done = 1'b0;
   logic       busy;
   logic       run_done;
   logic       timeout_err;
   logic [15:0] cycle_count;

   run_sequencer #(.ADDR_W(8), .DATA_W(8), .CNT_W(16), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ld_base(cmd_ld_base), .cmd_ld_len(cmd_ld_len),
      .cmd_rd_base(cmd_rd_base), .cmd_rd_len(cmd_rd_len),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_data(rs_data), .rs_last(rs_last),
      .mem_own(mem_own), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .dut_start(dut_start), .dut_done(dut_done),
      .busy(busy), .run_done(run_done),
      .timeout_err(timeout_err), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // data_mem model and reference copy of its intended contents
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] ld_buf [256];
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_own && mem_wen) mem[mem_addr] = mem_wdata;
   end

   // core model: raises done in the requested RUN cycle (0 = never)
   int done_after = 0;
   int run_cyc = 0;
   bit armed = 1'b0;
   always @(negedge clk) begin
      if (dut_start) begin
         run_cyc = 0;
         dut_done = 1'b0;
         armed = 1'b1;
      end else if (armed) begin
         run_cyc++;
         if (done_after != 0 && run_cyc >= done_after) dut_done = 1'b1;
      end
   end

   // result-stream backpressure: 0 random, 1 toggling, 2 always ready
   int rs_mode = 2;
   always @(posedge clk) begin
      #1;
      case (rs_mode)
         0: rs_ready = 1'($urandom_range(0, 1));
         1: rs_ready = ~rs_ready;
         default: rs_ready = 1'b1;
      endcase
   end

   // scoreboard
   wr_t   exp_wr[$];
   rs_t   exp_rs[$];
   done_t exp_done[$];
   int    exp_starts = 0;
   int    start_cycles = 0;

   wr_t   m_wr;
   rs_t   m_rs;
   done_t m_done;
   bit    stall_prev = 1'b0;
   logic [7:0] held_data, held_addr;
   logic  held_last;

   always @(negedge clk) begin
      if (reset) begin
         if (mem_wen) begin
            chk("wr_own", mem_own, 1);
            if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
               m_wr = exp_wr.pop_front();
               chk("wr_addr", mem_addr, m_wr.addr);
               chk("wr_data", mem_wdata, m_wr.data);
            end
         end
         if (stall_prev) begin
            chk("rs_stall_valid", rs_valid, 1);
            chk("rs_stall_data", rs_data, held_data);
            chk("rs_stall_addr", mem_addr, held_addr);
            chk("rs_stall_last", rs_last, held_last);
         end
         stall_prev = rs_valid && !rs_ready;
         held_data = rs_data;
         held_addr = mem_addr;
         held_last = rs_last;
         if (rs_valid && rs_ready) begin
            if (exp_rs.size() == 0) chk("rs_unexpected", 1, 0);
            else begin
               m_rs = exp_rs.pop_front();
               chk("rs_data", rs_data, m_rs.data);
               chk("rs_last", rs_last, m_rs.last);
            end
         end
         if (run_done) begin
            if (exp_done.size() == 0) chk("run_done_unexpected", 1, 0);
            else begin
               m_done = exp_done.pop_front();
               chk("timeout_err", timeout_err, m_done.to);
               chk("cycle_count", cycle_count, m_done.cyc);
            end
         end
         if (dut_start) begin
            start_cycles++;
            chk("start_own", mem_own, 0);
         end
         if (cmd_valid && busy) chk("cmd_ignored", cmd_ready, 0);
      end else begin
         stall_prev = 1'b0;
      end
   end

   logic        last_to = 1'b0;
   logic [15:0] last_cyc = '0;

   task automatic drive_beat(input logic [7:0] d, input int gap);
      int g;
      int n;
      ld_valid = 1'b1;
      ld_data = d;
      g = 0;
      do begin @(negedge clk); g++; end while (!ld_ready && g < 200);
      if (!ld_ready) chk("ld_ready_wait", 0, 1);
      @(posedge clk); #1;
      ld_valid = 1'b0;
      n = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic run_cmd(input logic [7:0] lb, input int ll, input logic [7:0] rb,
                          input int rl, input int da, input int gap, input bit spam);
      bit to;
      int cyc;
      int g;
      logic [7:0] a;
      to  = (da == 0) || (da > TMO - 1);
      cyc = to ? TMO - 1 : da;
      for (int i = 0; i < ll; i++) begin
         a = lb + 8'(i);
         exp_wr.push_back('{a, ld_buf[i]});
         ref_mem[a] = ld_buf[i];
      end
      if (!to) begin
         for (int i = 0; i < rl; i++) begin
            a = rb + 8'(i);
            exp_rs.push_back('{ref_mem[a], i == rl - 1});
         end
      end
      exp_done.push_back('{to, 16'(cyc)});
      exp_starts++;

      @(posedge clk); #1;
      chk("held_cycle_count", cycle_count, last_cyc);
      chk("held_timeout_err", timeout_err, last_to);
      done_after = da;
      cmd_ld_base = lb;
      cmd_ld_len = 9'(ll);
      cmd_rd_base = rb;
      cmd_rd_len = 9'(rl);
      cmd_valid = 1'b1;
      g = 0;
      do begin @(negedge clk); g++; end while (!cmd_ready && g < 100);
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (spam) begin
         cmd_ld_len = 9'd5;
         cmd_rd_len = 9'd7;
         cmd_valid = 1'b1;
         repeat (2) begin @(posedge clk); #1; end
         cmd_valid = 1'b0;
      end
      for (int i = 0; i < ll; i++) drive_beat(ld_buf[i], gap);
      g = 0;
      while (exp_done.size() != 0 && g < 4000) begin @(posedge clk); #1; g++; end
      if (exp_done.size() != 0) begin
         chk("run_done_wait", 0, 1);
         exp_done.delete();
         exp_rs.delete();
         exp_wr.delete();
      end
      last_to = to;
      last_cyc = 16'(cyc);
   endtask

   task automatic fill_buf();
      for (int i = 0; i < 256; i++) ld_buf[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom_range(0, 255));
         ref_mem[i] = mem[i];
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_rs_valid", rs_valid, 0);
      chk("rst_rs_data", rs_data, 0);
      chk("rst_rs_last", rs_last, 0);
      chk("rst_mem_own", mem_own, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_dut_start", dut_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_run_done", run_done, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_cycle_count", cycle_count, 0);
      reset = 1'b1;

      // basic preload / run / readback
      ld_buf[0] = 8'hAA; ld_buf[1] = 8'hBB; ld_buf[2] = 8'hCC;
      run_cmd(8'h10, 3, 8'h10, 3, 20, 0, 1'b0);
      chk("mem_10", mem[8'h10], 8'hAA);
      chk("mem_12", mem[8'h12], 8'hCC);

      // address wrap with gaps in the load stream
      fill_buf();
      run_cmd(8'hFE, 4, 8'hFE, 4, 5, 2, 1'b0);
      chk("mem_wrap_00", mem[8'h00], ld_buf[2]);
      chk("mem_wrap_01", mem[8'h01], ld_buf[3]);

      // core never finishes
      fill_buf();
      run_cmd(8'h20, 2, 8'h20, 3, 0, 1, 1'b0);

      // done and timeout in the same cycle, then done one cycle too late
      run_cmd(8'h00, 0, 8'h30, 2, TMO - 1, 0, 1'b0);
      run_cmd(8'h00, 0, 8'h30, 2, TMO, 0, 1'b0);

      // full 256-word readback under toggling backpressure
      rs_mode = 1;
      run_cmd(8'h00, 0, 8'h80, 256, 3, 0, 1'b0);
      rs_mode = 2;

      // asynchronous reset during the preload
      fill_buf();
      @(posedge clk); #1;
      done_after = 0;
      for (int i = 0; i < 2; i++) begin
         exp_wr.push_back('{8'h40 + 8'(i), ld_buf[i]});
         ref_mem[8'h40 + 8'(i)] = ld_buf[i];
      end
      cmd_ld_base = 8'h40; cmd_ld_len = 9'd5; cmd_rd_base = 8'h40; cmd_rd_len = 9'd5;
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("cmd_ready_pre_abort", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) drive_beat(ld_buf[i], 0);
      ld_valid = 1'b1;
      ld_data = ld_buf[2];
      reset = 1'b0;
      #1;
      chk("abort_cmd_ready", cmd_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_mem_wen", mem_wen, 0);
      chk("abort_ld_ready", ld_ready, 0);
      chk("abort_dut_start", dut_start, 0);
      repeat (3) @(posedge clk);
      #1;
      ld_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("post_abort_busy", busy, 0);
      chk("post_abort_cmd_ready", cmd_ready, 1);
      last_to = 1'b0;
      last_cyc = '0;
      // partial preload must remain in memory
      run_cmd(8'h00, 0, 8'h40, 5, 4, 0, 1'b0);

      // empty windows, done on first RUN cycle, commands offered while busy
      run_cmd(8'h00, 0, 8'h00, 0, 1, 0, 1'b1);

      // randomized commands
      for (int n = 0; n < 20; n++) begin
         fill_buf();
         rs_mode = int'($urandom_range(0, 2));
         run_cmd(8'($urandom_range(0, 255)), int'($urandom_range(0, 12)),
                 8'($urandom_range(0, 255)), int'($urandom_range(0, 12)),
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30)), -1, 1'b0);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("wr_queue_empty", exp_wr.size(), 0);
      chk("rs_queue_empty", exp_rs.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);
      chk("start_cycles", start_cycles, exp_starts);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
